// File: rtl/chart_sequencer.sv
// chart_sequencer: frame-synchronous note scheduler. Walks a beatmap held in a
// synchronous chart ROM and issues {ka, do} note requests on vsync boundaries.
//
// Handshake to the lane queues: request[x] is a valid that is held for exactly
// one frame, from one vsync to the next. lane_full[x] is the inverted ready. It
// is sampled only in the firing cycle. A note fired while its lane is full is
// not retried. It is dropped and counted in drop_cnt.
module chart_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              start,
  input  logic              pause,
  input  logic [1:0]        lane_full,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [1:0]        request,
  output logic              playing,
  output logic              done,
  output logic [15:0]       song_frame,
  output logic [DROP_W-1:0] drop_cnt,
  // Debug view of the FSM: 0 IDLE, 1 FETCH, 2 LOAD, 3 WAIT, 4 DONE
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [9:0]         wait_cnt;
  logic [1:0]         entry_lanes;   // {ka, do} of the entry being timed
  logic               tick;          // an unpaused frame tick
  logic               fire;
  logic               restart;
  logic               last_addr;
  logic [1:0]         fire_bits;
  logic [1:0]         drop_bits;
  logic [1:0]         drop_inc;
  logic [DROP_W:0]    drop_sum;
  logic               rsvd_unused;

  assign tick        = vsync && !pause;
  assign last_addr   = &rom_addr;
  assign playing     = (state == S_FETCH) || (state == S_LOAD) || (state == S_WAIT);
  assign done        = (state == S_DONE);
  assign fsm_state   = state;
  // Reserved entry bits carry no meaning.
  assign rsvd_unused = ^rom_data[12:10];

  // Next-state logic plus the fire/restart strobes and the drop arithmetic.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    restart   = 1'b0;
    fire_bits = 2'b00;
    drop_bits = 2'b00;
    drop_inc  = 2'b00;
    drop_sum  = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          restart   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = rom_data[15] ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (tick && (wait_cnt == 10'd0)) begin
          fire      = 1'b1;
          state_nxt = last_addr ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        if (start) begin
          restart   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (fire) begin
      fire_bits = entry_lanes & ~lane_full;
      drop_bits = entry_lanes & lane_full;
    end
    drop_inc = {1'b0, drop_bits[1]} + {1'b0, drop_bits[0]};
    drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(drop_inc);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Datapath: address walk, entry latch, frame countdown, requests and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_addr    <= '0;
      wait_cnt    <= 10'd0;
      entry_lanes <= 2'b00;
      request     <= 2'b00;
      song_frame  <= 16'd0;
      drop_cnt    <= '0;
    end else begin
      if (restart)
        rom_addr <= '0;
      else if (fire && !last_addr)
        rom_addr <= rom_addr + ADDR_W'(1);

      if (state == S_LOAD) begin
        wait_cnt    <= rom_data[9:0];
        entry_lanes <= rom_data[14:13];
      end else if ((state == S_WAIT) && tick && (wait_cnt != 10'd0)) begin
        wait_cnt <= wait_cnt - 10'd1;
      end

      // A request lives for exactly one frame: every vsync rewrites it.
      if (vsync)
        request <= fire_bits;

      if (restart)
        song_frame <= 16'd0;
      else if (tick && playing)
        song_frame <= song_frame + 16'd1;

      if (restart)
        drop_cnt <= '0;
      else if (fire)
        drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

endmodule

// File: doc/chart_sequencer.md
# chart_sequencer

Frame-synchronous note scheduler that replaces the free-running `do_ka_cnt` generator. It walks a beatmap stored in a synchronous chart ROM and issues `{ka, do}` note requests on exact frame boundaries to the two 8-slot lane queues. Requests aimed at a full lane are suppressed and counted. It also exposes play state and a song-frame counter for score and UI logic.

## Interface
- `ADDR_W`, default 10: chart ROM address width; chart holds up to 2^ADDR_W entries.
- `DROP_W`, default 8: width of the dropped-note counter.
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: synchronous reset, active-low. Clears all state when sampled low on a `clk` edge.
- `vsync` in 1: one-cycle frame tick (one-pulsed vsync). All frame timing is counted in these ticks.
- `start` in 1: one-cycle pulse that begins playback from address 0.
- `pause` in 1: level; while high, frame countdown and firing are frozen.
- `lane_full` in 2: `{ka_full, do_full}`; the corresponding lane queue cannot accept a note.
- `rom_addr` out ADDR_W: chart ROM address.
- `rom_data` in 16: ROM word, valid 1 cycle after `rom_addr`.
- `request` out 2: `{ka, do}` note requests to the lane queues.
- `playing` out 1: high in FETCH, LOAD and WAIT.
- `done` out 1: high in DONE.
- `song_frame` out 16: count of unpaused vsync ticks since start.
- `drop_cnt` out DROP_W: saturating count of suppressed lane requests.

## Operation
- Entry format:
  - [15] END.
  - [14] KA.
  - [13] DO.
  - [12:10] reserved; ignored.
  - [9:0] DELAY, in frames.
  - KA=DO=0 with END=0 is a rest entry: delay only, no request.
  - KA=DO=1 fires both lanes together.
- States: IDLE, FETCH, LOAD, WAIT, DONE.
  - IDLE: `rom_addr`=0. On `start` → FETCH.
  - FETCH: drive `rom_addr`; → LOAD next cycle.
  - LOAD: latch `rom_data`. If END=1 → DONE. Otherwise load `wait_cnt`=DELAY → WAIT.
  - WAIT, on a `vsync` cycle with `pause`=0:
    - If `wait_cnt`≠0: decrement it.
    - If `wait_cnt`=0: fire the entry. Then, if `rom_addr`=all-ones → DONE; else increment `rom_addr` → FETCH.
  - WAIT, on a `vsync` cycle with `pause`=1: state and `wait_cnt` hold.
  - DONE: holds `rom_addr`. On `start` → clear `rom_addr`, `song_frame`, `drop_cnt` → FETCH.
- `start` is ignored in FETCH, LOAD and WAIT.
- Firing: for each lane `x` in the entry:
  - If `lane_full[x]`=0 → set `request[x]`.
  - Otherwise → `request[x]`=0 and `drop_cnt`+1. Both lanes dropped in the same tick adds +2.
  - `drop_cnt` saturates at all-ones.
- `request` register:
  - Updated only on `vsync` cycles: set to the fire bits of that tick, else 0.
  - A request is therefore held for exactly one frame, and each lane queue samples it exactly once, at the next `vsync`.
- `song_frame` increments on every `vsync` while `playing`=1 and `pause`=0, and wraps at 2^16.

## Timing
- Reset values:
  - State IDLE.
  - `rom_addr`=0, `request`=0, `playing`=0, `done`=0, `song_frame`=0, `drop_cnt`=0.
  - `wait_cnt`=0.
- Entry with DELAY=d fires on the (d+1)-th `vsync` after entering WAIT. The decrement ticks and the firing tick count only when `pause`=0.
- FETCH+LOAD take 2 `clk` cycles. A following DELAY=0 entry therefore fires on the very next `vsync` (one frame later). The frame period is far longer than 2 cycles.
- `vsync` arriving during FETCH or LOAD:
  - Clears `request`.
  - Counts in `song_frame`.
  - Does not decrement or fire.
- `pause` rising while `request`≠0: `request` still clears at the next `vsync`.
- `lane_full` is sampled only in the firing cycle.
- Reset mid-playback: abandon the current entry. All outputs go to reset values on the next edge. Pending requests are lost.

## Test plan
- Chart {DO d=2, KA d=0, END}, `start` then vsync ticks V1..V5:
  - `request`=01 from V3 to V4.
  - `request`=10 from V4 to V5.
  - `done`=1 two cycles after V4.
  - `song_frame`=4 at V4.
- Same chart, `lane_full`=01 held during V3:
  - `request` stays 00 across V3.
  - `drop_cnt`=1.
  - KA still fires at V4.
- DO d=3 with `pause`=1 over 5 ticks after V1:
  - Firing is delayed by exactly 5 ticks.
  - `song_frame` does not advance while paused.
- Rest entry d=1023 then DO d=0:
  - `request`=01 appears on the 1025th vsync after entering WAIT.
  - No request before that.
- Mid-WAIT `rst`=0 for 1 cycle:
  - All outputs 0; state IDLE.
  - A `start` pulse while playing is ignored.
  - `start` after DONE restarts from `rom_addr`=0 with `drop_cnt`=0.
- Chart filled to address all-ones with no END entry (`ADDR_W`=2, 4 DO d=0 entries):
  - Exactly 4 requests are issued.
  - Then `done`=1 and `rom_addr`=3.
